// File: rtl/eeg_xram_rd_fetch.sv
// eeg_xram_rd_fetch: strided read fetch sequencer for one XRAM lane.
// Turns a (base, step, length) command into an address stream, captures the
// returned words into a small output FIFO and forwards them with
// valid/ready/last. Address issue is credit-limited against the FIFO, so
// XRAM_DAT_RDY can stay high whenever the block is out of reset.
//
// state | meaning
// IDLE  | waiting for a command, CMD_RDY high
// ISSUE | sending addresses while FIFO credit allows
// DRAIN | last address sent, waiting for its data to be captured
module eeg_xram_rd_fetch #(
  parameter int XRAM_ADD_AW = 12,
  parameter int XRAM_DAT_DW = 8,
  parameter int CMD_LEN_DW  = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   CMD_VLD,
  output logic                   CMD_RDY,
  input  logic [XRAM_ADD_AW-1:0] CMD_ADD,
  input  logic [XRAM_ADD_AW-1:0] CMD_STP,
  input  logic [CMD_LEN_DW-1:0]  CMD_LEN,
  output logic                   XRAM_ADD_VLD,
  output logic                   XRAM_ADD_LST,
  input  logic                   XRAM_ADD_RDY,
  output logic [XRAM_ADD_AW-1:0] XRAM_ADD_ADD,
  input  logic                   XRAM_DAT_VLD,
  input  logic                   XRAM_DAT_LST,
  output logic                   XRAM_DAT_RDY,
  input  logic [XRAM_DAT_DW-1:0] XRAM_DAT_DAT,
  output logic                   OUT_VLD,
  output logic                   OUT_LST,
  input  logic                   OUT_RDY,
  output logic [XRAM_DAT_DW-1:0] OUT_DAT,
  output logic                   BUSY
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state;
  logic [XRAM_ADD_AW-1:0] cur_add;
  logic [XRAM_ADD_AW-1:0] stp;
  logic [CMD_LEN_DW-1:0]  len;
  logic [CMD_LEN_DW-1:0]  cnt;
  logic                   inflight;

  logic [XRAM_DAT_DW:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          fifo_cnt;
  logic [XRAM_DAT_DW:0]   fifo_head;
  logic                   fifo_vld;

  logic [CW:0]            credit_use;
  logic                   credit_ok;
  logic                   add_hs;
  logic                   push;
  logic                   pop;

  // The word already in flight holds a FIFO slot; same-cycle pops are
  // deliberately ignored so the credit check stays conservative.
  assign credit_use = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
  assign credit_ok  = credit_use < DEPTH_C;
  assign fifo_vld   = fifo_cnt != '0;
  assign fifo_head  = fifo_mem[rd_ptr];

  // All outputs are held low while reset is asserted.
  assign CMD_RDY      = rst_n && (state == IDLE);
  assign XRAM_ADD_VLD = rst_n && (state == ISSUE) && credit_ok;
  assign XRAM_ADD_LST = rst_n && (state == ISSUE) && (cnt == len);
  assign XRAM_ADD_ADD = rst_n ? cur_add : '0;
  assign XRAM_DAT_RDY = rst_n;
  assign OUT_VLD      = rst_n && fifo_vld;
  assign OUT_LST      = OUT_VLD && fifo_head[XRAM_DAT_DW];
  assign OUT_DAT      = OUT_VLD ? fifo_head[XRAM_DAT_DW-1:0] : '0;
  assign BUSY         = rst_n && ((state != IDLE) || fifo_vld);

  assign add_hs = XRAM_ADD_VLD && XRAM_ADD_RDY;
  assign push   = inflight && XRAM_DAT_VLD;
  assign pop    = OUT_VLD && OUT_RDY;

  // Command sequencing: latch the command, walk the strided addresses, wait for last data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_add  <= '0;
      stp      <= '0;
      len      <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= add_hs;
      case (state)
        IDLE: begin
          if (CMD_VLD) begin
            cur_add <= CMD_ADD;
            stp     <= CMD_STP;
            len     <= CMD_LEN;
            cnt     <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (add_hs) begin
            cur_add <= cur_add + stp;
            cnt     <= cnt + 1'b1;
            if (cnt == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (push && XRAM_DAT_LST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (rst_n && push) fifo_mem[wr_ptr] <= {XRAM_DAT_LST, XRAM_DAT_DAT};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Credit accounting must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_cnt == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_eeg_xram_rd_fetch.sv
module tb_eeg_xram_rd_fetch;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int LW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CMD_VLD = 1'b0;
  logic          CMD_RDY;
  logic [AW-1:0] CMD_ADD = '0;
  logic [AW-1:0] CMD_STP = '0;
  logic [LW-1:0] CMD_LEN = '0;
  logic          XRAM_ADD_VLD;
  logic          XRAM_ADD_LST;
  logic          XRAM_ADD_RDY = 1'b0;
  logic [AW-1:0] XRAM_ADD_ADD;
  logic          XRAM_DAT_VLD = 1'b0;
  logic          XRAM_DAT_LST = 1'b0;
  logic          XRAM_DAT_RDY;
  logic [DW-1:0] XRAM_DAT_DAT = '0;
  logic          OUT_VLD;
  logic          OUT_LST;
  logic          OUT_RDY = 1'b0;
  logic [DW-1:0] OUT_DAT;
  logic          BUSY;

  eeg_xram_rd_fetch #(
    .XRAM_ADD_AW(AW), .XRAM_DAT_DW(DW), .CMD_LEN_DW(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_ADD(CMD_ADD), .CMD_STP(CMD_STP), .CMD_LEN(CMD_LEN),
    .XRAM_ADD_VLD(XRAM_ADD_VLD), .XRAM_ADD_LST(XRAM_ADD_LST), .XRAM_ADD_RDY(XRAM_ADD_RDY),
    .XRAM_ADD_ADD(XRAM_ADD_ADD),
    .XRAM_DAT_VLD(XRAM_DAT_VLD), .XRAM_DAT_LST(XRAM_DAT_LST), .XRAM_DAT_RDY(XRAM_DAT_RDY),
    .XRAM_DAT_DAT(XRAM_DAT_DAT),
    .OUT_VLD(OUT_VLD), .OUT_LST(OUT_LST), .OUT_RDY(OUT_RDY), .OUT_DAT(OUT_DAT),
    .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus knobs (percent probabilities)
  int add_pct = 100;
  int out_pct = 100;
  int spur_pct = 0;

  // reference model state
  logic [AW:0] exp_add[$];
  logic [DW:0] exp_out[$];
  logic [AW:0] add_log[$];
  logic [DW:0] out_log[$];
  int issued = 0, popped = 0, n_hs = 0;
  int acc_cyc = 0, first_hs_cyc = -1, last_hs_cyc = -1, first_out_cyc = -1, idle_cyc = -1;
  logic hs, hs_q = 1'b0, hs_lst_q = 1'b0;
  logic [AW-1:0] hs_add_q = '0;
  logic prev_stall = 1'b0;
  logic [DW:0] prev_out = '0;
  logic busy_s = 1'b0, add_vld_s = 1'b0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (lo + lo + lo) ^ {4'h0, a[11:8]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
  endtask

  // XRAM responder and ready generators
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hs_q) begin
        XRAM_DAT_VLD = 1'b1;
        XRAM_DAT_DAT = memf(hs_add_q);
        XRAM_DAT_LST = hs_lst_q;
      end else begin
        XRAM_DAT_VLD = int'($urandom_range(99)) < spur_pct;
        XRAM_DAT_DAT = DW'($urandom);
        XRAM_DAT_LST = 1'($urandom);
      end
      XRAM_ADD_RDY = int'($urandom_range(99)) < add_pct;
      OUT_RDY      = int'($urandom_range(99)) < out_pct;
    end
  end

  // compare process: checks every cycle against the queue model
  initial begin
    logic [AW:0] ea;
    logic [DW:0] eo;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      hs = XRAM_ADD_VLD && XRAM_ADD_RDY;
      if (!rst_n) begin
        chk("reset_outputs", {23'd0, CMD_RDY, XRAM_ADD_VLD, XRAM_ADD_LST, XRAM_DAT_RDY, OUT_VLD,
                              OUT_LST, BUSY, |XRAM_ADD_ADD, |OUT_DAT}, 32'd0);
        exp_add.delete();
        exp_out.delete();
        issued = 0;
        popped = 0;
        prev_stall = 1'b0;
      end else begin
        chk("dat_rdy", XRAM_DAT_RDY, 1);
        chk("busy", BUSY, exp_out.size() != 0);
        if (prev_stall) chk("out_hold", {OUT_VLD, OUT_LST, OUT_DAT}, {1'b1, prev_out});
        if (hs) begin
          if (exp_add.size() == 0) fail("unexpected_addr", $sformatf("got addr %0h, expected none", XRAM_ADD_ADD));
          else begin
            ea = exp_add.pop_front();
            chk("addr", {XRAM_ADD_LST, XRAM_ADD_ADD}, ea);
          end
          add_log.push_back({XRAM_ADD_LST, XRAM_ADD_ADD});
          issued++;
          n_hs++;
          last_hs_cyc = cyc;
          if (first_hs_cyc < 0) first_hs_cyc = cyc;
        end
        if (OUT_VLD && OUT_RDY) begin
          if (exp_out.size() == 0) fail("unexpected_out", $sformatf("got data %0h, expected none", OUT_DAT));
          else begin
            eo = exp_out.pop_front();
            chk("out", {OUT_LST, OUT_DAT}, eo);
          end
          out_log.push_back({OUT_LST, OUT_DAT});
          popped++;
          if (first_out_cyc < 0) first_out_cyc = cyc;
        end
        chk("credit", (issued - popped) <= DEPTH, 1);
        if (CMD_VLD && CMD_RDY) begin
          a = CMD_ADD;
          for (int i = 0; i <= int'(CMD_LEN); i++) begin
            exp_add.push_back({i == int'(CMD_LEN), a});
            exp_out.push_back({i == int'(CMD_LEN), memf(a)});
            a = a + CMD_STP;
          end
          acc_cyc = cyc;
          first_hs_cyc = -1;
          first_out_cyc = -1;
          idle_cyc = -1;
          n_hs = 0;
        end else if (CMD_RDY && idle_cyc < 0) begin
          idle_cyc = cyc;
        end
        prev_stall = OUT_VLD && !OUT_RDY;
        prev_out = {OUT_LST, OUT_DAT};
      end
      hs_q = hs;
      hs_add_q = XRAM_ADD_ADD;
      hs_lst_q = XRAM_ADD_LST;
      busy_s = BUSY;
      add_vld_s = XRAM_ADD_VLD;
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] s, input logic [LW-1:0] l);
    int k;
    k = 0;
    @(posedge clk);
    #1;
    CMD_VLD = 1'b1;
    CMD_ADD = a;
    CMD_STP = s;
    CMD_LEN = l;
    do begin
      @(negedge clk);
      k++;
    end while (!CMD_RDY && k < 400);
    if (!CMD_RDY) fail("cmd_accept_timeout", "got CMD_RDY=0, expected 1");
    @(posedge clk);
    #1;
    CMD_VLD = 1'b0;
    CMD_ADD = AW'($urandom);
    CMD_STP = AW'($urandom);
    CMD_LEN = LW'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(exp_out.size() == 0 && exp_add.size() == 0 && !busy_s) && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (!(exp_out.size() == 0 && exp_add.size() == 0 && !busy_s))
      fail("idle_timeout", $sformatf("got %0d words pending, expected 0", exp_out.size()));
  endtask

  task automatic clear_logs();
    add_log.delete();
    out_log.delete();
  endtask

  task automatic chk_adds(input string nm, input logic [AW:0] e[$]);
    chk({nm, "_count"}, add_log.size(), e.size());
    if (add_log.size() == e.size())
      foreach (e[i]) chk(nm, add_log[i], e[i]);
  endtask

  task automatic chk_outs(input string nm, input logic [DW:0] e[$]);
    chk({nm, "_count"}, out_log.size(), e.size());
    if (out_log.size() == e.size())
      foreach (e[i]) chk(nm, out_log[i], e[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW:0] qa[$];
    logic [DW:0] qo[$];
    int k;
    logic [AW-1:0] rs;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_rdy", CMD_RDY, 1);
    chk("post_reset_dat_rdy", XRAM_DAT_RDY, 1);

    // single command, latency and consecutive addresses
    clear_logs();
    send_cmd(12'h010, 12'd1, 12'd3);
    wait_idle(100);
    qa = {13'h0010, 13'h0011, 13'h0012, 13'h1013};
    chk_adds("t1_addr", qa);
    qo = {9'h030, 9'h033, 9'h036, 9'h139};
    chk_outs("t1_out", qo);
    chk("t1_first_addr_cycle", first_hs_cyc - acc_cyc, 1);
    chk("t1_last_addr_cycle", last_hs_cyc - acc_cyc, 4);
    chk("t1_first_out_cycle", first_out_cyc - acc_cyc, 3);

    // address wrap
    clear_logs();
    send_cmd(12'hFFE, 12'd2, 12'd2);
    wait_idle(100);
    qa = {13'h0FFE, 13'h0000, 13'h1002};
    chk_adds("t2_addr", qa);
    qo = {9'h0F5, 9'h000, 9'h106};
    chk_outs("t2_out", qo);

    // backpressure: credit stops issue after four words
    clear_logs();
    out_pct = 0;
    send_cmd(12'h200, 12'd1, 12'd15);
    repeat (20) @(posedge clk);
    chk("t3_hs_count", n_hs, 4);
    chk("t3_add_vld_stalled", add_vld_s, 0);
    chk("t3_busy", busy_s, 1);
    out_pct = 100;
    wait_idle(200);
    chk("t3_out_count", out_log.size(), 16);

    // single-word command
    clear_logs();
    send_cmd(12'h123, 12'd0, 12'd0);
    wait_idle(100);
    qa = {13'h1123};
    chk_adds("t4_addr", qa);
    qo = {9'h168};
    chk_outs("t4_out", qo);
    chk("t4_idle_cycle", idle_cyc - acc_cyc, 3);

    // back-to-back commands with random consumer
    clear_logs();
    out_pct = 50;
    send_cmd(12'h000, 12'd1, 12'd1);
    send_cmd(12'h800, 12'd1, 12'd1);
    wait_idle(200);
    qo = {9'h000, 9'h103, 9'h008, 9'h10B};
    chk_outs("t5_out", qo);

    // reset in the middle of issue
    out_pct = 100;
    send_cmd(12'h300, 12'd1, 12'd7);
    k = 0;
    while (n_hs < 3 && k < 50) begin
      @(posedge clk);
      k++;
    end
    chk("t6_reached_issue", n_hs >= 3, 1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_out_vld", OUT_VLD, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_cmd_rdy", CMD_RDY, 1);
    spur_pct = 100;
    repeat (4) @(posedge clk);
    spur_pct = 0;
    clear_logs();
    send_cmd(12'h040, 12'd3, 12'd5);
    wait_idle(100);
    chk("t6_out_count", out_log.size(), 6);
    if (add_log.size() == 6) chk("t6_last_addr", add_log[5], 13'h104F);
    else fail("t6_addr_count", $sformatf("got %0d, expected 6", add_log.size()));

    // random traffic with stalls and spurious data strobes
    add_pct = 70;
    out_pct = 60;
    spur_pct = 20;
    for (int c = 0; c < 30; c++) begin
      case ($urandom_range(3))
        0: rs = 12'd0;
        1: rs = 12'd1;
        2: rs = 12'hFFF;
        default: rs = AW'($urandom);
      endcase
      send_cmd(AW'($urandom), rs, LW'($urandom_range(9)));
      if ($urandom_range(1) == 0) wait_idle(500);
    end
    wait_idle(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
